// File: rtl/hermes_mem_pkg.sv
// Shared types for the data-memory arbiter: access sizes and sequencer states.
package hermes_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_BYTE   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } block_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT_RDY,
        WR_WAIT_FIN,
        RESP
    } state_e;

    // Number of bytes covered by one access of the given size.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (block_size_e'(size))
            SIZE_WORD:   size_bytes = 4'd4;
            SIZE_HALF:   size_bytes = 4'd2;
            SIZE_BYTE:   size_bytes = 4'd1;
            default:     size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input round-robin arbiter; the grant is combinational, history is registered.
module mem_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    // Port that won most recently; reset to 1 so port 0 wins the first tie.
    logic r_last;

    // One-hot grant: a lone requester wins, a tie goes to the other port.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Remember the winner whenever a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (i_en && (|i_req))
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-client data-memory arbiter/sequencer with alignment check and timeout.
module data_mem_arbiter
    import hermes_mem_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             cl_valid,
    input  logic [1:0]             cl_write,
    input  logic [1:0][ADDR_W-1:0] cl_addr,
    input  logic [1:0][1:0]        cl_size,
    input  logic [1:0][DATA_W-1:0] cl_wdata,
    output logic [1:0]             cl_ready,
    output logic                   rsp_valid,
    output logic                   rsp_port,
    output logic                   rsp_error,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_read_request,
    output logic                   mem_write_request,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [1:0]             mem_block_size,
    output logic [DATA_W-1:0]      mem_write_data,
    input  logic                   mem_read_ready,
    input  logic                   mem_write_ready,
    input  logic                   mem_write_finished,
    input  logic [DATA_W-1:0]      mem_read_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_cl_ready;
    logic                r_rsp_valid, r_rsp_port, r_rsp_error;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rd_req, r_wr_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_port, r_err;

    logic [1:0]          w_gnt;
    logic                w_win, w_misalign, w_tmo;
    logic [3:0]          w_bytes;
    logic [DATA_W-1:0]   w_mask;
    logic                w_grant, w_fire, w_fire_err, w_rd_req, w_wr_req;
    logic                w_cnt_clr, w_cnt_inc;
    logic [DATA_W-1:0]   w_fire_data;

    mem_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (cl_valid),
        .i_en  (w_grant),
        .o_gnt (w_gnt)
    );

    assign w_win      = w_gnt[1];
    assign w_bytes    = size_bytes(cl_size[w_win]);
    assign w_misalign = (cl_addr[w_win][3:0] & (w_bytes - 4'd1)) != 4'd0;
    assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Byte-lane mask for the latched access size, used to zero-extend load data.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++)
            w_mask[i] = (i < 8 * int'(size_bytes(r_size)));
    end

    // Next state and registered-output intents. In the wait states the first cycle
    // only raises the request; memory events count once the request is visible.
    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_fire      = 1'b0;
        w_fire_err  = 1'b0;
        w_fire_data = '0;
        w_rd_req    = 1'b0;
        w_wr_req    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|cl_valid) begin
                    w_grant   = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (w_misalign)         w_next = RESP;
                    else if (cl_write[w_win]) w_next = WR_WAIT_RDY;
                    else                    w_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!r_rd_req) begin
                    w_rd_req = 1'b1;
                end else if (mem_read_ready) begin
                    w_fire      = 1'b1;
                    w_fire_data = mem_read_data & w_mask;
                    w_next      = RESP;
                end else if (w_tmo) begin
                    w_fire     = 1'b1;
                    w_fire_err = 1'b1;
                    w_next     = RESP;
                end else begin
                    w_rd_req  = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            WR_WAIT_RDY: begin
                if (!r_wr_req) begin
                    w_wr_req = 1'b1;
                end else if (mem_write_ready && mem_write_finished) begin
                    w_fire = 1'b1;
                    w_next = RESP;
                end else if (mem_write_ready) begin
                    w_cnt_clr = 1'b1;
                    w_next    = WR_WAIT_FIN;
                end else if (w_tmo) begin
                    w_fire     = 1'b1;
                    w_fire_err = 1'b1;
                    w_next     = RESP;
                end else begin
                    w_wr_req  = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            WR_WAIT_FIN: begin
                if (mem_write_finished) begin
                    w_fire = 1'b1;
                    w_next = RESP;
                end else if (w_tmo) begin
                    w_fire     = 1'b1;
                    w_fire_err = 1'b1;
                    w_next     = RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RESP: begin
                // A misaligned grant lands here before its response is raised.
                if (r_rsp_valid) begin
                    w_next = IDLE;
                end else begin
                    w_fire     = 1'b1;
                    w_fire_err = r_err;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register and wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Latch the winning client's request; these also drive the memory fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_port  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_addr  <= cl_addr[w_win];
            r_size  <= cl_size[w_win];
            r_wdata <= cl_wdata[w_win];
            r_port  <= w_win;
            r_err   <= w_misalign;
        end
    end

    // Registered handshake outputs: accept pulse, memory requests, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cl_ready  <= '0;
            r_rd_req    <= 1'b0;
            r_wr_req    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_cl_ready  <= w_grant ? w_gnt : 2'b00;
            r_rd_req    <= w_rd_req;
            r_wr_req    <= w_wr_req;
            r_rsp_valid <= w_fire;
            r_rsp_port  <= w_fire & r_port;
            r_rsp_error <= w_fire & w_fire_err;
            r_rsp_rdata <= w_fire ? w_fire_data : '0;
        end
    end

    assign cl_ready          = r_cl_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_port          = r_rsp_port;
    assign rsp_error         = r_rsp_error;
    assign rsp_rdata         = r_rsp_rdata;
    assign mem_read_request  = r_rd_req;
    assign mem_write_request = r_wr_req;
    assign mem_address       = r_addr;
    assign mem_block_size    = r_size;
    assign mem_write_data    = r_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests, memory model, monitor.
module tb_data_mem_arbiter;

    localparam int TMO = 20;

    logic             clk, rst_n;
    logic [1:0]       cl_valid, cl_write, cl_ready;
    logic [1:0][63:0] cl_addr, cl_wdata;
    logic [1:0][1:0]  cl_size;
    logic             rsp_valid, rsp_port, rsp_error;
    logic [63:0]      rsp_rdata;
    logic             mem_read_request, mem_write_request;
    logic [63:0]      mem_address, mem_write_data, mem_read_data;
    logic [1:0]       mem_block_size;
    logic             mem_read_ready, mem_write_ready, mem_write_finished;

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cl_valid(cl_valid), .cl_write(cl_write), .cl_addr(cl_addr),
        .cl_size(cl_size), .cl_wdata(cl_wdata), .cl_ready(cl_ready),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata),
        .mem_read_request(mem_read_request), .mem_write_request(mem_write_request),
        .mem_address(mem_address), .mem_block_size(mem_block_size),
        .mem_write_data(mem_write_data), .mem_read_ready(mem_read_ready),
        .mem_write_ready(mem_write_ready), .mem_write_finished(mem_write_finished),
        .mem_read_data(mem_read_data)
    );

    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    logic gnt_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t_gnt = 0, t_rsp = 0, n_grants = 0, n_rd_req = 0, n_wr_req = 0;

    // memory model controls and captures
    int rd_delay = 0, wr_rdy_delay = 0, fin_delay = 3;
    bit mem_silent = 0, fin_same = 0;
    logic [63:0] cap_addr = '0, cap_wdata = '0;
    logic [1:0]  cap_size = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory model: reacts to requests seen at the falling edge.
    initial begin
        int rd_cnt = 0, wr_cnt = 0, fin_cnt = 0;
        bit fin_pend = 0;
        mem_read_ready = 0; mem_write_ready = 0; mem_write_finished = 0;
        forever begin
            @(negedge clk);
            mem_read_ready = 0; mem_write_ready = 0; mem_write_finished = 0;
            if (!rst_n) begin
                rd_cnt = 0; wr_cnt = 0; fin_pend = 0;
            end else begin
                if (fin_pend) begin
                    fin_cnt++;
                    if (fin_cnt == fin_delay) begin
                        mem_write_finished = 1;
                        fin_pend = 0;
                    end
                end
                if (mem_read_request) begin
                    if (!mem_silent && rd_cnt == rd_delay) mem_read_ready = 1;
                    rd_cnt++;
                end else rd_cnt = 0;
                if (mem_write_request) begin
                    if (wr_cnt == wr_rdy_delay) begin
                        mem_write_ready = 1;
                        cap_addr = mem_address; cap_wdata = mem_write_data; cap_size = mem_block_size;
                        if (fin_same) mem_write_finished = 1;
                        else begin fin_pend = 1; fin_cnt = 0; end
                    end
                    wr_cnt++;
                end else wr_cnt = 0;
            end
        end
    end

    // Monitor: checks grants and responses against the scoreboard queues.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mem_read_request) n_rd_req++;
        if (mem_write_request) n_wr_req++;
        if (mem_read_request || mem_write_request)
            chk("req_mutex", {63'd0, mem_read_request & mem_write_request}, 64'd0);
        if (cl_ready != 2'b00) begin
            t_gnt = cyc;
            n_grants++;
            chk("grant_onehot", {63'd0, $onehot(cl_ready)}, 64'd1);
            if (gnt_q.size() == 0) fail_now("unexpected_grant");
            else chk("grant_port", {63'd0, cl_ready[1]}, {63'd0, gnt_q.pop_front()});
        end
        if (rsp_valid) begin
            t_rsp = cyc;
            chk("req_low_at_rsp", {62'd0, mem_read_request, mem_write_request}, 64'd0);
            if (sb_q.size() == 0) fail_now("unexpected_rsp");
            else begin
                e = sb_q.pop_front();
                chk("rsp_port", {63'd0, rsp_port}, {63'd0, e.port});
                chk("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic p, input logic err, input logic [63:0] rd);
        exp_t e;
        e.port = p; e.err = err; e.rdata = rd;
        sb_q.push_back(e);
        gnt_q.push_back(p);
    endtask

    task automatic issue(input int p, input logic wr, input logic [63:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input logic err, input logic [63:0] rd);
        int i;
        expect_rsp(p[0], err, rd);
        cl_write[p] = wr; cl_addr[p] = a; cl_size[p] = sz; cl_wdata[p] = wd;
        cl_valid[p] = 1'b1;
        for (i = 0; i < 50; i++) begin
            tick();
            if (cl_ready[p]) break;
        end
        if (i == 50) fail_now("grant_wait");
        cl_valid[p] = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && gnt_q.size() == 0) break;
            tick();
        end
        if (i == 200) fail_now("done_wait");
        tick();
    endtask

    task automatic wait_grants(input int n);
        int tgt, i;
        tgt = n_grants + n;
        for (i = 0; i < 200; i++) begin
            if (n_grants >= tgt) break;
            tick();
        end
        if (n_grants < tgt) fail_now("grants_wait");
    endtask

    initial begin
        rst_n = 0;
        cl_valid = '0; cl_write = '0; cl_addr = '0; cl_size = '0; cl_wdata = '0;
        mem_read_data = '0;
        // both clients loading while reset is held
        cl_addr[0] = 64'h100; cl_size[0] = 2'b11;
        cl_addr[1] = 64'h204; cl_size[1] = 2'b00;
        cl_valid = 2'b11;
        tick(); tick();
        chk("reset_outputs", {cl_ready, rsp_valid, rsp_port, rsp_error, mem_read_request,
                              mem_write_request, mem_block_size} , 64'd0);
        chk("reset_addr_data", mem_address | mem_write_data | rsp_rdata, 64'd0);

        // alternating grants from reset, minimum latency loads
        mem_read_data = 64'h0123_4567_89AB_CDEF; rd_delay = 0;
        expect_rsp(0, 0, 64'h0123_4567_89AB_CDEF);
        expect_rsp(1, 0, 64'h0000_0000_89AB_CDEF);
        expect_rsp(0, 0, 64'h0123_4567_89AB_CDEF);
        expect_rsp(1, 0, 64'h0000_0000_89AB_CDEF);
        rst_n = 1;
        wait_grants(4);
        cl_valid = 2'b00;
        wait_done();
        chk("min_load_latency", t_rsp - t_gnt, 2);

        // double load, ready two cycles after request
        mem_read_data = 64'hDEAD_BEEF_CAFE_F00D; rd_delay = 2;
        issue(0, 0, 64'h10, 2'b11, 0, 0, 64'hDEAD_BEEF_CAFE_F00D);
        wait_done();
        chk("load_latency", t_rsp - t_gnt, 4);

        // byte store, finished three cycles after ready
        n_wr_req = 0; wr_rdy_delay = 0; fin_delay = 3; fin_same = 0;
        issue(1, 1, 64'h20, 2'b10, 64'hAB, 0, 64'h0);
        wait_done();
        chk("store_req_cycles", n_wr_req, 1);
        chk("store_latency", t_rsp - t_gnt, 5);
        chk("store_addr", cap_addr, 64'h20);
        chk("store_wdata", cap_wdata, 64'hAB);
        chk("store_size", {62'd0, cap_size}, 64'd2);

        // misaligned word load: error, no memory access
        n_rd_req = 0;
        issue(0, 0, 64'h3, 2'b00, 0, 1, 64'h0);
        wait_done();
        chk("misalign_no_req", n_rd_req, 0);
        chk("misalign_latency", t_rsp - t_gnt, 1);

        // half and byte loads are zero-extended
        mem_read_data = 64'hFFEE_DDCC_BBAA_9988; rd_delay = 1;
        issue(1, 0, 64'h32, 2'b01, 0, 0, 64'h9988);
        wait_done();
        issue(0, 0, 64'h7, 2'b10, 0, 0, 64'h88);
        wait_done();

        // silent memory: timeout after exactly TMO request cycles
        n_rd_req = 0; mem_silent = 1;
        issue(0, 0, 64'h48, 2'b11, 0, 1, 64'h0);
        wait_done();
        mem_silent = 0;
        chk("timeout_req_cycles", n_rd_req, TMO);
        chk("timeout_latency", t_rsp - t_gnt, TMO + 1);

        // ready and finished together skip the finish wait
        n_wr_req = 0; wr_rdy_delay = 1; fin_same = 1;
        issue(0, 1, 64'h6, 2'b01, 64'h1234, 0, 64'h0);
        wait_done();
        chk("store_same_latency", t_rsp - t_gnt, 3);
        chk("store_same_req_cycles", n_wr_req, 2);
        fin_same = 0; wr_rdy_delay = 0;

        // misaligned double on port 1
        issue(1, 0, 64'h44, 2'b11, 0, 1, 64'h0);
        wait_done();

        // reset while waiting for store commit
        fin_delay = 100;
        issue(0, 1, 64'h40, 2'b11, 64'h55AA, 0, 64'h0);
        tick(); tick(); tick();
        chk("pre_reset_addr", mem_address, 64'h40);
        chk("pre_reset_wreq_dropped", {63'd0, mem_write_request}, 64'd0);
        #2 rst_n = 0;
        #1;
        chk("async_reset_outputs", {cl_ready, rsp_valid, rsp_port, rsp_error, mem_read_request,
                                    mem_write_request, mem_block_size}, 64'd0);
        chk("async_reset_addr", mem_address | mem_write_data | rsp_rdata, 64'd0);
        sb_q.delete();
        gnt_q.delete();
        tick(); tick();
        fin_delay = 3; rd_delay = 0;
        mem_read_data = 64'h0123_4567_89AB_CDEF;
        cl_write = '0;
        cl_addr[0] = 64'h100; cl_size[0] = 2'b11;
        cl_addr[1] = 64'h204; cl_size[1] = 2'b00;
        expect_rsp(0, 0, 64'h0123_4567_89AB_CDEF);
        expect_rsp(1, 0, 64'h0000_0000_89AB_CDEF);
        cl_valid = 2'b11;
        rst_n = 1;
        wait_grants(2);
        cl_valid = 2'b00;
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the data memory. Accepts load/store requests from two clients (port 0: load/store unit, port 1: debug/DMA port), grants one at a time round-robin, drives the memory's request/ready/finished handshake, and returns a single-cycle response to the granted client. It also rejects misaligned accesses and times out a memory that never answers.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT_CYCLES, 255, maximum wait cycles for memory ready/finished before an error response

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cl_valid  in  [1:0]  client request valid, held until accepted
- cl_write  in  [1:0]  1 = store, 0 = load
- cl_addr  in  [1:0][ADDR_W-1:0]  client address
- cl_size  in  [1:0][1:0]  block size: 00 word, 01 half, 10 byte, 11 double
- cl_wdata  in  [1:0][DATA_W-1:0]  store data, LSB-aligned
- cl_ready  out  [1:0]  one-cycle accept pulse, one-hot or zero
- rsp_valid  out  1  one-cycle response pulse
- rsp_port  out  1  client the response belongs to
- rsp_error  out  1  misaligned or timeout
- rsp_rdata  out  DATA_W  load data, zero-extended to size; 0 for stores and errors
- mem_read_request / mem_write_request  out  1  memory requests, mutually exclusive
- mem_address  out  ADDR_W;  mem_block_size  out  2;  mem_write_data  out  DATA_W
- mem_read_ready  in  1  load data valid on mem_read_data this cycle
- mem_write_ready  in  1  store accepted
- mem_write_finished  in  1  store committed
- mem_read_data  in  DATA_W

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT_RDY, WR_WAIT_FIN, RESP.
- IDLE: if any cl_valid, pick winner (round-robin below), pulse cl_ready[winner], latch addr/size/wdata/write/port. Misaligned (addr mod bytes(size) != 0) -> RESP with error, no memory access. Else -> RD_WAIT or WR_WAIT_RDY.
- Round-robin: last_grant register, reset 1 (port 0 wins first). One requester: it wins. Both: the one != last_grant. Updated on every grant, including misaligned ones.
- RD_WAIT: mem_read_request held high with latched fields. On mem_read_ready: capture mem_read_data masked to size, -> RESP.
- WR_WAIT_RDY: mem_write_request high. On mem_write_ready: drop request -> WR_WAIT_FIN. mem_write_ready and mem_write_finished in the same cycle -> RESP directly.
- WR_WAIT_FIN: requests low; on mem_write_finished -> RESP.
- Timeout counter cleared on entry to each wait state; increments each wait cycle; reaching TIMEOUT_CYCLES with no event -> RESP with error, requests dropped.
- RESP: rsp_valid=1 for one cycle with port, error, rdata -> IDLE. No grant in RESP.
- Memory inputs arriving in states that do not expect them are ignored.

## Timing
- Reset values: cl_ready 0, rsp_valid 0, rsp_port 0, rsp_error 0, rsp_rdata 0, mem_* requests 0, mem_address/size/write_data 0, state IDLE, counter 0.
- All outputs registered. Grant cycle T: cl_ready pulses at T. Memory request asserted from T+1.
- Load with mem_read_ready at cycle R: rsp_valid at R+1. Minimum load latency valid->rsp_valid = 3 cycles (ready on first request cycle).
- Misaligned: rsp_valid at T+1, no memory request.
- Back-to-back: next grant no earlier than cycle after rsp_valid.
- rst_n low mid-transaction: all state and outputs to reset values immediately; in-flight transaction dropped, no response.

## Structure
- Package hermes_mem_pkg: block_size enum (SIZE_WORD=00, SIZE_HALF=01, SIZE_BYTE=10, SIZE_DOUBLE=11), function size_bytes(), FSM state enum.
- Sub-module mem_rr_arbiter: 2-input round-robin with last_grant register, grant enable input, one-hot grant output.

## Test plan
- Port 0 load, addr 0x10, size 11, memory ready 2 cycles after request, data 0xDEADBEEF_CAFEF00D -> rsp_valid port 0, error 0, rdata 0xDEADBEEF_CAFEF00D.
- Both valid continuously from reset, loads -> grants 0,1,0,1; responses alternate ports.
- Port 1 store, addr 0x20, size 10, wdata 0xAB; write_ready then write_finished 3 cycles later -> mem_write_request high only until ready; rsp_valid 1 cycle after finished, rdata 0.
- Port 0 load addr 0x3, size 00 -> rsp_error=1 one cycle after grant, mem_read_request never asserted.
- Load, memory silent -> rsp_error=1 after exactly TIMEOUT_CYCLES wait cycles; request deasserted.
- rst_n asserted in WR_WAIT_FIN -> all outputs 0 asynchronously; after release, port 0 granted first.
